spi_word_assembler: RTL and testbench

Byte-to-word front end feeding the raytracing controller's 64-bit scene-update port. Collects bytes from the SPI slave byte receiver, packs each group of 8 (first byte = MSB) into a `Types::Sphere`-compatible word, and holds it in a one-entry buffer. The buffer drains into the controller only while the controller signals it is ready. The block also drives the MCU request line and reports framing and overrun errors.

---
 rtl/spi_word_assembler.sv | 129 ++++++++++++
 tb/tb_spi_word_assembler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_assembler.sv
// Packs SPI bytes (first byte = MSB) into words held in a one-entry buffer; last byte to recv_dv is 2 cycles.
// Backpressure: the buffer drains only while ready_in=1; a word completing into a full, non-draining buffer is dropped and flagged.
module spi_word_assembler #(
  parameter int BYTES  = 8,
  parameter int WORD_W = 64
) (
  input  logic              CLK100MHZ,
  input  logic              ck_rst_,
  input  logic              byte_dv,
  input  logic [7:0]        byte_in,
  input  logic              cs_n,
  input  logic              ready_in,
  input  logic              err_clr,
  output logic              recv_dv,
  output logic [WORD_W-1:0] recv_64bit,
  output logic              mcu_irq,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              shift_en;
  logic              frame_end;

  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] hold;
  logic              hold_v;

  logic [WORD_W-1:0] word_full;
  logic              word_done;
  logic              drain;
  logic              hold_load;
  logic              overrun_set;
  logic              frame_err_set;

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame end has priority over a byte strobe arriving on the same cycle.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_n) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else begin
          shift_en = byte_dv;
        end
      end
    endcase
  end

  assign word_full     = {sr[WORD_W-9:0], byte_in};
  assign word_done     = shift_en && (byte_cnt == LAST_BYTE);
  assign drain         = hold_v && ready_in;
  assign hold_load     = word_done && (!hold_v || drain);
  assign overrun_set   = word_done && hold_v && !ready_in;
  assign frame_err_set = frame_end && (byte_cnt != '0);

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      byte_cnt <= '0;
      sr       <= '0;
    end else if (frame_end) begin
      byte_cnt <= '0;
      sr       <= '0;
    end else if (shift_en) begin
      sr       <= word_full;
      byte_cnt <= word_done ? '0 : byte_cnt + CNT_W'(1);
    end
  end

  // A word completing while the buffer drains refills it on the same edge.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      hold       <= '0;
      hold_v     <= 1'b0;
      recv_dv    <= 1'b0;
      recv_64bit <= '0;
    end else begin
      recv_dv <= drain;
      if (drain) begin
        recv_64bit <= hold;
      end
      if (hold_load) begin
        hold   <= word_full;
        hold_v <= 1'b1;
      end else if (drain) begin
        hold_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      mcu_irq   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mcu_irq   <= ready_in && !hold_v && cs_n;
      overrun   <= overrun_set   || (overrun   && !err_clr);
      frame_err <= frame_err_set || (frame_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_spi_word_assembler.sv
// Bench for spi_word_assembler: a vector table, directed multi-cycle sequences and random traffic against a queue-based model.
module tb_spi_word_assembler;

  localparam int BYTES  = 8;
  localparam int WORD_W = 64;

  logic              CLK100MHZ = 1'b0;
  logic              ck_rst_   = 1'b1;
  logic              byte_dv   = 1'b0;
  logic [7:0]        byte_in   = 8'h00;
  logic              cs_n      = 1'b1;
  logic              ready_in  = 1'b1;
  logic              err_clr   = 1'b0;
  logic              recv_dv;
  logic [WORD_W-1:0] recv_64bit;
  logic              mcu_irq;
  logic              overrun;
  logic              frame_err;

  spi_word_assembler #(.BYTES(BYTES), .WORD_W(WORD_W)) dut (
    .CLK100MHZ (CLK100MHZ),
    .ck_rst_   (ck_rst_),
    .byte_dv   (byte_dv),
    .byte_in   (byte_in),
    .cs_n      (cs_n),
    .ready_in  (ready_in),
    .err_clr   (err_clr),
    .recv_dv   (recv_dv),
    .recv_64bit(recv_64bit),
    .mcu_irq   (mcu_irq),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int total = 0;
  int bad   = 0;
  int dv_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the word in progress kept as a queue, words built arithmetically.
  bit         m_in_frame;
  bit [7:0]   m_bytes[$];
  bit         m_hv;
  bit [63:0]  m_hold;
  bit         m_dv;
  bit [63:0]  m_out;
  bit         m_irq;
  bit         m_ovr;
  bit         m_ferr;

  task automatic model_reset();
    m_in_frame = 0;
    m_bytes.delete();
    m_hv   = 0;
    m_hold = '0;
    m_dv   = 0;
    m_out  = '0;
    m_irq  = 0;
    m_ovr  = 0;
    m_ferr = 0;
  endtask

  task automatic model_step();
    bit drain, hv_next, ovr_set, ferr_set;
    bit [63:0] w;
    ovr_set  = 0;
    ferr_set = 0;
    hv_next  = m_hv;
    drain    = m_hv && ready_in;
    m_irq    = ready_in && !m_hv && cs_n;
    m_dv     = drain;
    if (drain) begin
      m_out   = m_hold;
      hv_next = 0;
    end
    if (m_in_frame && cs_n) begin
      if (m_bytes.size() != 0) ferr_set = 1;
      m_bytes.delete();
    end else if (m_in_frame && byte_dv) begin
      m_bytes.push_back(byte_in);
      if (m_bytes.size() == BYTES) begin
        w = 0;
        foreach (m_bytes[i]) w = w * 256 + 64'(m_bytes[i]);
        if (!m_hv || drain) begin
          m_hold  = w;
          hv_next = 1;
        end else begin
          ovr_set = 1;
        end
        m_bytes.delete();
      end
    end
    m_hv       = hv_next;
    m_ovr      = ovr_set  || (m_ovr  && !err_clr);
    m_ferr     = ferr_set || (m_ferr && !err_clr);
    m_in_frame = !cs_n;
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    if (!ck_rst_) model_reset();
    else model_step();
    #1;
    if (recv_dv === 1'b1) dv_count++;
    check("m_recv_dv",   64'(recv_dv),   64'(m_dv));
    check("m_recv_word", recv_64bit,     m_out);
    check("m_mcu_irq",   64'(mcu_irq),   64'(m_irq));
    check("m_overrun",   64'(overrun),   64'(m_ovr));
    check("m_frame_err", 64'(frame_err), 64'(m_ferr));
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_dv = 1'b1;
    byte_in = b;
    tick();
    byte_dv = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = BYTES - 1; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic frame(input logic [63:0] w);
    cs_n = 1'b0;
    tick();
    send_word(w);
    cs_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        cs;
    logic        dv;
    logic [7:0]  b;
    logic        rdy;
    logic        clr;
    logic        e_dv;
    logic [63:0] e_word;
    logic        e_irq;
    logic        e_ovr;
    logic        e_ferr;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] sw_bytes[8];
  localparam logic [63:0] SW = 64'h0064FE7003228000;

  initial begin
    int base;
    logic [63:0] c2;

    sw_bytes = '{8'h00, 8'h64, 8'hFE, 8'h70, 8'h03, 8'h22, 8'h80, 8'h00};
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[2+i] = '{1'b0, 1'b1, sw_bytes[i], 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, SW, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, SW, 1'b1, 1'b0, 1'b0};

    model_reset();
    #1 ck_rst_ = 1'b0;
    tick();
    tick();
    check("rst_recv_dv",   64'(recv_dv),   64'h0);
    check("rst_recv_word", recv_64bit,     64'h0);
    check("rst_mcu_irq",   64'(mcu_irq),   64'h0);
    check("rst_overrun",   64'(overrun),   64'h0);
    check("rst_frame_err", 64'(frame_err), 64'h0);
    ck_rst_ = 1'b1;

    // Single word, table driven
    for (int v = 0; v < 12; v++) begin
      cs_n     = vecs[v].cs;
      byte_dv  = vecs[v].dv;
      byte_in  = vecs[v].b;
      ready_in = vecs[v].rdy;
      err_clr  = vecs[v].clr;
      tick();
      check($sformatf("vec%0d_recv_dv", v),   64'(recv_dv),   64'(vecs[v].e_dv));
      check($sformatf("vec%0d_word", v),      recv_64bit,     vecs[v].e_word);
      check($sformatf("vec%0d_mcu_irq", v),   64'(mcu_irq),   64'(vecs[v].e_irq));
      check($sformatf("vec%0d_overrun", v),   64'(overrun),   64'(vecs[v].e_ovr));
      check($sformatf("vec%0d_frame_err", v), 64'(frame_err), 64'(vecs[v].e_ferr));
    end
    byte_dv = 1'b0;

    // Back-pressure
    ready_in = 1'b0;
    tick();
    base = dv_count;
    frame(SW);
    repeat (50) tick();
    check("bp_no_dv",  64'(dv_count - base), 64'd0);
    check("bp_irq_lo", 64'(mcu_irq), 64'h0);
    ready_in = 1'b1;
    tick();
    check("bp_dv",   64'(recv_dv), 64'h1);
    check("bp_word", recv_64bit, SW);
    tick();
    tick();
    check("bp_irq_hi", 64'(mcu_irq), 64'h1);

    // Overrun
    ready_in = 1'b0;
    tick();
    base = dv_count;
    cs_n = 1'b0;
    tick();
    send_word(64'h0102030405060708);
    send_word(64'h1112131415161718);
    cs_n = 1'b1;
    tick();
    check("ovr_set", 64'(overrun), 64'h1);
    ready_in = 1'b1;
    tick();
    check("ovr_dv",   64'(recv_dv), 64'h1);
    check("ovr_word", recv_64bit, 64'h0102030405060708);
    repeat (5) tick();
    check("ovr_one_word", 64'(dv_count - base), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_clr", 64'(overrun), 64'h0);

    // Partial frame then a clean frame
    base = dv_count;
    cs_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    cs_n = 1'b1;
    tick();
    check("part_ferr",  64'(frame_err), 64'h1);
    check("part_no_dv", 64'(dv_count - base), 64'd0);
    frame(64'hAAAAAAAAAAAAAAAA);
    repeat (3) tick();
    check("part_next_cnt",  64'(dv_count - base), 64'd1);
    check("part_next_word", recv_64bit, 64'hAAAAAAAAAAAAAAAA);

    // Drain/complete collision
    ready_in = 1'b0;
    tick();
    base = dv_count;
    c2 = 64'hC2C3C4C5C6C7C8C9;
    cs_n = 1'b0;
    tick();
    send_word(64'hB1B2B3B4B5B6B7B8);
    for (int i = BYTES - 1; i >= 1; i--) send_byte(c2[8*i +: 8]);
    byte_dv  = 1'b1;
    byte_in  = c2[7:0];
    ready_in = 1'b1;
    tick();
    byte_dv = 1'b0;
    check("col_dv1",   64'(recv_dv), 64'h1);
    check("col_word1", recv_64bit, 64'hB1B2B3B4B5B6B7B8);
    tick();
    check("col_dv2",   64'(recv_dv), 64'h1);
    check("col_word2", recv_64bit, c2);
    check("col_no_ovr", 64'(overrun), 64'h0);
    cs_n = 1'b1;
    tick();
    tick();
    check("col_cnt", 64'(dv_count - base), 64'd2);

    // Reset mid-frame; frame_err is still set from the partial frame above
    cs_n = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
    #2 ck_rst_ = 1'b0;
    #1;
    check("mrst_recv_dv",   64'(recv_dv),   64'h0);
    check("mrst_recv_word", recv_64bit,     64'h0);
    check("mrst_mcu_irq",   64'(mcu_irq),   64'h0);
    check("mrst_overrun",   64'(overrun),   64'h0);
    check("mrst_frame_err", 64'(frame_err), 64'h0);
    model_reset();
    tick();
    tick();
    ck_rst_ = 1'b1;
    base = dv_count;
    tick();
    send_word(64'h5A5B5C5D5E5F6061);
    cs_n = 1'b1;
    tick();
    repeat (3) tick();
    check("mrst_cnt",  64'(dv_count - base), 64'd1);
    check("mrst_word", recv_64bit, 64'h5A5B5C5D5E5F6061);
    check("mrst_ferr", 64'(frame_err), 64'h0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) cs_n = ~cs_n;
      byte_dv = ($urandom_range(0, 2) != 0);
      byte_in = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ready_in = ~ready_in;
      err_clr = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
